// File: rtl/pulse_evt_arbiter_if.sv
// Event handshake bundle between the edge arbiter (master) and the shared consumer (slave).
interface pulse_evt_arbiter_if #(
    parameter int IDW = 2
) ();
    logic           evt_valid;
    logic           evt_ready;
    logic [IDW-1:0] evt_id;

    modport master (output evt_valid, output evt_id, input evt_ready);
    modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/pulse_evt_arbiter.sv
// Multi-channel rising-edge detector with round-robin hand-off of pending events.
// Optional sticky overflow flags (ovf/ovf_clr) are built when PULSE_EVT_OVF_EN is defined.
module pulse_evt_arbiter #(
    parameter int N_CH = 4,
    parameter int IDW  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  x,
    input  logic             en,
    pulse_evt_arbiter_if.master evt,
    output logic [N_CH-1:0]  pend,
    output logic             busy
`ifdef PULSE_EVT_OVF_EN
    ,
    output logic [N_CH-1:0]  ovf,
    input  logic             ovf_clr
`endif
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_OFFER = 1'b1;

    logic [0:0]      state;
    logic [N_CH-1:0] x_q;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] clr_mask;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  grant;
    logic            grant_found;
    logic            hs;
    int              idx;

    assign rise = x & ~x_q;
    assign hs   = (state == S_OFFER) & evt.evt_ready;
    assign busy = (state == S_OFFER) | (|pend);

    always_comb begin
        clr_mask = '0;
        if (hs) begin
            clr_mask[evt.evt_id] = 1'b1;
        end
    end

    // First pending channel at or after ptr, wrapping at N_CH rather than at 2**IDW.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        idx         = 0;
        for (int k = 0; k < N_CH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!grant_found && pend[idx[IDW-1:0]]) begin
                grant       = idx[IDW-1:0];
                grant_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q           <= '1;
            pend          <= '0;
            ptr           <= '0;
            state         <= S_IDLE;
            evt.evt_valid <= 1'b0;
            evt.evt_id    <= '0;
        end else begin
            x_q  <= x;
            pend <= (pend & ~clr_mask) | rise;
            case (state)
                S_IDLE: begin
                    if (en && grant_found) begin
                        evt.evt_id    <= grant;
                        evt.evt_valid <= 1'b1;
                        state         <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (evt.evt_ready) begin
                        ptr           <= (evt.evt_id == IDW'(N_CH - 1)) ? '0 : evt.evt_id + IDW'(1);
                        evt.evt_valid <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    evt.evt_valid <= 1'b0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PULSE_EVT_OVF_EN
    // An edge that lands on a still-pending channel is lost; setting wins over a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= '0;
        end else begin
            ovf <= (ovf & {N_CH{~ovf_clr}}) | (rise & pend & ~clr_mask);
        end
    end
`endif

endmodule

// File: tb/tb_pulse_evt_arbiter.sv
// Directed self-checking bench for pulse_evt_arbiter; ovf checks run only when PULSE_EVT_OVF_EN is defined.
module tb_pulse_evt_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] x;
    logic       en;
    logic [3:0] pend;
    logic       busy;
`ifdef PULSE_EVT_OVF_EN
    logic [3:0] ovf;
    logic       ovf_clr;
`endif

    int nCompared;
    int nMismatched;

    pulse_evt_arbiter_if #(.IDW(2)) evt_if ();

    pulse_evt_arbiter #(.N_CH(4), .IDW(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .x       (x),
        .en      (en),
        .evt     (evt_if),
        .pend    (pend),
        .busy    (busy)
`ifdef PULSE_EVT_OVF_EN
        ,
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] xv, input logic env, input logic rdy);
        x                = xv;
        en               = env;
        evt_if.evt_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        reset       = 1'b0;
        applyStimulus(4'b1111, 1'b1, 1'b0);
`ifdef PULSE_EVT_OVF_EN
        ovf_clr = 1'b0;
`endif
        tick();
        tick();
        checkOutput("rst_valid", 32'(evt_if.evt_valid), 32'd0);
        checkOutput("rst_id", 32'(evt_if.evt_id), 32'd0);
        checkOutput("rst_pend", 32'(pend), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);

        // Lines high across reset release must not create events.
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checkOutput("t1_pend", 32'(pend), 32'd0);
        checkOutput("t1_valid", 32'(evt_if.evt_valid), 32'd0);

        // Single edge on channel 2.
        applyStimulus(4'b1011, 1'b1, 1'b1);
        tick();
        checkOutput("t2_pend_pre", 32'(pend), 32'd0);
        applyStimulus(4'b1111, 1'b1, 1'b1);
        tick();
        checkOutput("t2_pend_e0", 32'(pend), 32'b0100);
        checkOutput("t2_valid_e0", 32'(evt_if.evt_valid), 32'd0);
        tick();
        checkOutput("t2_valid_e1", 32'(evt_if.evt_valid), 32'd1);
        checkOutput("t2_id_e1", 32'(evt_if.evt_id), 32'd2);
        checkOutput("t2_busy_e1", 32'(busy), 32'd1);
        tick();
        checkOutput("t2_valid_e2", 32'(evt_if.evt_valid), 32'd0);
        checkOutput("t2_pend_e2", 32'(pend), 32'd0);
        checkOutput("t2_busy_e2", 32'(busy), 32'd0);

        // Simultaneous edges on 0,1,3 from ptr=0, then wrap back to 0.
        doReset();
        applyStimulus(4'b0000, 1'b1, 1'b1);
        tick();
        applyStimulus(4'b1011, 1'b1, 1'b1);
        tick();
        checkOutput("t3_pend", 32'(pend), 32'b1011);
        tick();
        checkOutput("t3_id_a", 32'(evt_if.evt_id), 32'd0);
        checkOutput("t3_valid_a", 32'(evt_if.evt_valid), 32'd1);
        tick();
        checkOutput("t3_gap_a", 32'(evt_if.evt_valid), 32'd0);
        checkOutput("t3_pend_a", 32'(pend), 32'b1010);
        tick();
        checkOutput("t3_id_b", 32'(evt_if.evt_id), 32'd1);
        tick();
        checkOutput("t3_pend_b", 32'(pend), 32'b1000);
        tick();
        checkOutput("t3_id_c", 32'(evt_if.evt_id), 32'd3);
        checkOutput("t3_valid_c", 32'(evt_if.evt_valid), 32'd1);
        tick();
        checkOutput("t3_pend_c", 32'(pend), 32'd0);
        applyStimulus(4'b0010, 1'b1, 1'b1);
        tick();
        applyStimulus(4'b1011, 1'b1, 1'b1);
        tick();
        checkOutput("t3_pend_wrap", 32'(pend), 32'b1001);
        tick();
        checkOutput("t3_id_wrap", 32'(evt_if.evt_id), 32'd0);
        tick();
        tick();
        checkOutput("t3_id_wrap2", 32'(evt_if.evt_id), 32'd3);
        tick();

        // Stalled offer with en dropped stays stable and completes.
        doReset();
        applyStimulus(4'b0000, 1'b1, 1'b0);
        tick();
        applyStimulus(4'b0010, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("t4_valid_start", 32'(evt_if.evt_valid), 32'd1);
        applyStimulus(4'b1010, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("t4_hold_valid", 32'(evt_if.evt_valid), 32'd1);
            checkOutput("t4_hold_id", 32'(evt_if.evt_id), 32'd1);
        end
        checkOutput("t4_pend_hold", 32'(pend), 32'b1010);
        applyStimulus(4'b1010, 1'b0, 1'b1);
        tick();
        checkOutput("t4_valid_hs", 32'(evt_if.evt_valid), 32'd0);
        checkOutput("t4_pend_hs", 32'(pend), 32'b1000);
        tick();
        tick();
        checkOutput("t4_no_offer", 32'(evt_if.evt_valid), 32'd0);
        checkOutput("t4_busy_idle", 32'(busy), 32'd1);
        applyStimulus(4'b1010, 1'b1, 1'b1);
        tick();
        checkOutput("t4_en_valid", 32'(evt_if.evt_valid), 32'd1);
        checkOutput("t4_en_id", 32'(evt_if.evt_id), 32'd3);
        tick();
        checkOutput("t4_pend_end", 32'(pend), 32'd0);

`ifdef PULSE_EVT_OVF_EN
        // Repeated edge on a pending channel flags overflow and merges.
        doReset();
        applyStimulus(4'b0000, 1'b1, 1'b0);
        tick();
        applyStimulus(4'b0010, 1'b1, 1'b0);
        tick();
        checkOutput("t5_ovf_first", 32'(ovf), 32'd0);
        tick();
        applyStimulus(4'b0000, 1'b1, 1'b0);
        tick();
        applyStimulus(4'b0010, 1'b1, 1'b0);
        tick();
        checkOutput("t5_ovf_set", 32'(ovf), 32'b0010);
        applyStimulus(4'b0010, 1'b1, 1'b1);
        tick();
        checkOutput("t5_pend_hs", 32'(pend), 32'd0);
        applyStimulus(4'b0010, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("t5_one_event", 32'(evt_if.evt_valid), 32'd0);
        checkOutput("t5_ovf_sticky", 32'(ovf), 32'b0010);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checkOutput("t5_ovf_clr", 32'(ovf), 32'd0);
`endif

        // Async reset during an offer; ptr must restart at 0.
        doReset();
        applyStimulus(4'b0000, 1'b1, 1'b1);
        tick();
        applyStimulus(4'b0100, 1'b1, 1'b1);
        tick();
        tick();
        tick();
        applyStimulus(4'b0110, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("t6_valid_pre", 32'(evt_if.evt_valid), 32'd1);
        checkOutput("t6_id_pre", 32'(evt_if.evt_id), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t6_valid_async", 32'(evt_if.evt_valid), 32'd0);
        checkOutput("t6_pend_async", 32'(pend), 32'd0);
        checkOutput("t6_busy_async", 32'(busy), 32'd0);
        applyStimulus(4'b0000, 1'b1, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        applyStimulus(4'b1010, 1'b1, 1'b1);
        tick();
        checkOutput("t6_pend_after", 32'(pend), 32'b1010);
        tick();
        checkOutput("t6_id_ptr0", 32'(evt_if.evt_id), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
